// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
// Contents:
//   XLEN, NREG, RIDX_W  - register width, register count, index width
//   wb_req_t            - one queued write-back request {rd, data}
//   wb_src_e            - write-back source identifier (ALU / LSU)
//   rd_onehot()         - decode a register index into an NREG-wide bitmap
package regfile_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int RIDX_W = 5;

  typedef struct packed {
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  function automatic logic [NREG-1:0] rd_onehot(input logic [RIDX_W-1:0] rd);
    logic [NREG-1:0] map;
    map     = '0;
    map[rd] = 1'b1;
    return map;
  endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// wb_fifo: small synchronous FIFO of write-back requests.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (empties the FIFO)
//   push        - enqueue push_req (ignored when full)
//   push_req    - request to enqueue
//   pop         - dequeue the head (ignored when empty)
//   head        - oldest entry, meaningful only when !empty
//   full, empty - occupancy flags, derived from registered pointers only
//   rd_map      - OR of the decoded rd of every valid entry
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  wb_req_t         push_req,
  input  logic            pop,
  output wb_req_t         head,
  output logic            full,
  output logic            empty,
  output logic [NREG-1:0] rd_map
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  // The extra pointer MSB separates "wrapped onto the read slot" (full)
  // from "caught up with the reader" (empty).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_idx];

  // Storage needs no reset; slot_valid alone says what is live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_req;
    end
  end

  // A push and a pop in the same cycle always address different slots:
  // equal indices mean empty (no pop) or full (no push).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      slot_valid <= '0;
    end else begin
      if (do_push) begin
        wr_ptr             <= wr_ptr + (AW+1)'(1);
        slot_valid[wr_idx] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr             <= rd_ptr + (AW+1)'(1);
        slot_valid[rd_idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_map = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        rd_map = rd_map | rd_onehot(mem[i].rd);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// the ALU and LSU write-back sources. Each source has its own queue, the
// queue heads are granted round-robin, and the granted head is registered
// onto the write port. A pending bitmap marks every register with a write
// still queued or issuing.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   alu_valid/ready/rd/data          - ALU write-back handshake
//   lsu_valid/ready/rd/data          - LSU write-back handshake
//   rf_we, rf_rd, rf_wdata           - register file RegWrite / RD / WriteData
//   rf_src                           - source of the current write (0 ALU, 1 LSU)
//   pending                          - per-register write-in-flight bitmap
// XLEN and NREG must match the values in regfile_pkg; the queued request
// type is built from the package constants.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN   = regfile_pkg::XLEN,
  parameter int NREG   = regfile_pkg::NREG,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [RIDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [RIDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              rf_we,
  output logic [RIDX_W-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              rf_src,
  output logic [NREG-1:0]   pending
);

  wb_req_t         alu_in;
  wb_req_t         lsu_in;
  wb_req_t         alu_head;
  wb_req_t         lsu_head;
  logic            alu_full;
  logic            alu_empty;
  logic            lsu_full;
  logic            lsu_empty;
  logic            alu_push;
  logic            lsu_push;
  logic            alu_pop;
  logic            lsu_pop;
  logic            tie;
  logic [NREG-1:0] alu_map;
  logic [NREG-1:0] lsu_map;
  logic [NREG-1:0] issue_map;
  wb_src_e         last_grant;
  wb_src_e         src_q;

  // Readiness depends only on registered occupancy, so a full queue stays
  // closed even in the cycle it pops.
  assign alu_ready = !alu_full && !reset;
  assign lsu_ready = !lsu_full && !reset;

  // Writes to x0 complete the handshake but never enter a queue.
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign alu_in   = '{rd: alu_rd, data: alu_data};
  assign lsu_in   = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(.DEPTH(QDEPTH)) u_alu_q (
    .clk     (clk),
    .reset   (reset),
    .push    (alu_push),
    .push_req(alu_in),
    .pop     (alu_pop),
    .head    (alu_head),
    .full    (alu_full),
    .empty   (alu_empty),
    .rd_map  (alu_map)
  );

  wb_fifo #(.DEPTH(QDEPTH)) u_lsu_q (
    .clk     (clk),
    .reset   (reset),
    .push    (lsu_push),
    .push_req(lsu_in),
    .pop     (lsu_pop),
    .head    (lsu_head),
    .full    (lsu_full),
    .empty   (lsu_empty),
    .rd_map  (lsu_map)
  );

  // On a tie the source that did not win the previous tie gets the port.
  assign tie     = !alu_empty && !lsu_empty;
  assign alu_pop = !alu_empty && (lsu_empty || (last_grant == SRC_LSU));
  assign lsu_pop = !lsu_empty && !alu_pop;

  // Output register for the write port. Without a grant only rf_we drops;
  // rd, data and source keep their last values. last_grant only moves on
  // a contested cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      src_q      <= SRC_ALU;
      last_grant <= SRC_LSU;
    end else if (alu_pop) begin
      rf_we    <= 1'b1;
      rf_rd    <= alu_head.rd;
      rf_wdata <= alu_head.data;
      src_q    <= SRC_ALU;
      if (tie) begin
        last_grant <= SRC_ALU;
      end
    end else if (lsu_pop) begin
      rf_we    <= 1'b1;
      rf_rd    <= lsu_head.rd;
      rf_wdata <= lsu_head.data;
      src_q    <= SRC_LSU;
      if (tie) begin
        last_grant <= SRC_LSU;
      end
    end else begin
      rf_we <= 1'b0;
    end
  end

  assign rf_src = src_q;

  always_comb begin
    issue_map = '0;
    if (rf_we) begin
      issue_map = rd_onehot(rf_rd);
    end
  end

  // x0 never has a write in flight.
  assign pending = (alu_map | lsu_map | issue_map) & {{(NREG-1){1'b1}}, 1'b0};

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// A queue-based reference model predicts every output each cycle; directed
// tests additionally pin write order, latency and pending behaviour to
// hand-computed constants.
module tb_regfile_wb_arbiter;

  localparam int QD = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } req_t;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd    = '0;
  logic [63:0] alu_data  = '0;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd    = '0;
  logic [63:0] lsu_data  = '0;
  logic        alu_ready;
  logic        lsu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;
  logic        rf_src;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.XLEN(64), .NREG(32), .QDEPTH(QD)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_rd   (lsu_rd),
    .lsu_data (lsu_data),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_wdata (rf_wdata),
    .rf_src   (rf_src),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Requests waiting to be offered, one queue per source.
  req_t alu_drv[$];
  req_t lsu_drv[$];

  task automatic applyStimulus(input bit is_lsu, input logic [4:0] rd, input logic [63:0] data);
    req_t r;
    r.rd   = rd;
    r.data = data;
    if (is_lsu) lsu_drv.push_back(r);
    else        alu_drv.push_back(r);
  endtask

  // Reference model state: queued writes per source plus the write port.
  req_t        m_alu[$];
  req_t        m_lsu[$];
  logic        m_init = 1'b0;
  logic        m_we   = 1'b0;
  logic [4:0]  m_rd   = '0;
  logic [63:0] m_data = '0;
  logic        m_src  = 1'b0;
  logic        m_last = 1'b1;
  logic        grant_a;
  logic        grant_l;
  logic [31:0] exp_pend;

  logic s_alu_fire = 1'b0;
  logic s_lsu_fire = 1'b0;
  logic s_reset    = 1'b1;
  req_t s_alu_req;
  req_t s_lsu_req;

  // Compare against the model mid-cycle, then capture this cycle's
  // handshakes for the model update at the coming edge.
  always @(negedge clk) begin
    if (m_init) begin
      exp_pend = '0;
      foreach (m_alu[i]) exp_pend[m_alu[i].rd] = 1'b1;
      foreach (m_lsu[i]) exp_pend[m_lsu[i].rd] = 1'b1;
      if (m_we) exp_pend[m_rd] = 1'b1;
      exp_pend[0] = 1'b0;
      checkOutput("model_rf_we", rf_we, m_we);
      checkOutput("model_rf_rd", rf_rd, m_rd);
      checkOutput("model_rf_wdata", rf_wdata, m_data);
      checkOutput("model_rf_src", rf_src, m_src);
      checkOutput("model_pending", pending, exp_pend);
      checkOutput("model_alu_ready", alu_ready, (!reset && (m_alu.size() < QD)));
      checkOutput("model_lsu_ready", lsu_ready, (!reset && (m_lsu.size() < QD)));
    end
    s_alu_fire = alu_valid && alu_ready;
    s_lsu_fire = lsu_valid && lsu_ready;
    s_reset    = reset;
    s_alu_req  = '{rd: alu_rd, data: alu_data};
    s_lsu_req  = '{rd: lsu_rd, data: lsu_data};
  end

  // Model update at the edge, then drive the next offered requests.
  always @(posedge clk) begin
    if (s_reset) begin
      m_alu.delete();
      m_lsu.delete();
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
      m_src  = 1'b0;
      m_last = 1'b1;
      m_init = 1'b1;
    end else begin
      grant_a = (m_alu.size() > 0) && ((m_lsu.size() == 0) || m_last);
      grant_l = (m_lsu.size() > 0) && !grant_a;
      if (grant_a || grant_l) begin
        if ((m_alu.size() > 0) && (m_lsu.size() > 0)) m_last = grant_l;
        m_we = 1'b1;
        if (grant_a) begin
          m_rd   = m_alu[0].rd;
          m_data = m_alu[0].data;
          m_src  = 1'b0;
          m_alu.delete(0);
        end else begin
          m_rd   = m_lsu[0].rd;
          m_data = m_lsu[0].data;
          m_src  = 1'b1;
          m_lsu.delete(0);
        end
      end else begin
        m_we = 1'b0;
      end
      if (s_alu_fire && (s_alu_req.rd != 5'd0)) m_alu.push_back(s_alu_req);
      if (s_lsu_fire && (s_lsu_req.rd != 5'd0)) m_lsu.push_back(s_lsu_req);
    end
    if (s_alu_fire && (alu_drv.size() > 0)) alu_drv.delete(0);
    if (s_lsu_fire && (lsu_drv.size() > 0)) lsu_drv.delete(0);
    #1;
    alu_valid = (alu_drv.size() > 0);
    if (alu_valid) begin
      alu_rd   = alu_drv[0].rd;
      alu_data = alu_drv[0].data;
    end
    lsu_valid = (lsu_drv.size() > 0);
    if (lsu_valid) begin
      lsu_rd   = lsu_drv[0].rd;
      lsu_data = lsu_drv[0].data;
    end
  end

  // Per-cycle history captured by observe(); index k = k-th negedge.
  logic        h_we   [32];
  logic [4:0]  h_rd   [32];
  logic [63:0] h_data [32];
  logic        h_src  [32];
  logic [31:0] h_pend [32];
  logic        h_ardy [32];
  logic        h_lrdy [32];
  logic        h_aval [32];
  logic        h_lval [32];

  task automatic observe(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      h_we[k]   = rf_we;
      h_rd[k]   = rf_rd;
      h_data[k] = rf_wdata;
      h_src[k]  = rf_src;
      h_pend[k] = pending;
      h_ardy[k] = alu_ready;
      h_lrdy[k] = lsu_ready;
      h_aval[k] = alu_valid;
      h_lval[k] = lsu_valid;
    end
  endtask

  task automatic alignStart();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (((alu_drv.size() > 0) || (lsu_drv.size() > 0) || rf_we || (pending != '0)) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL idle_timeout: got %0d cycles, expected below 200", n);
    end
  endtask

  initial begin
    logic [31:0] vec;
    logic [31:0] por;
    int          stall;
    int          awr[$];
    int          lwr[$];
    int          exp_rr_rd[6]  = '{1, 4, 2, 5, 3, 6};
    int          exp_rr_src[6] = '{0, 1, 0, 1, 0, 1};
    int          exp_a[4]      = '{20, 21, 22, 23};
    int          exp_l[6]      = '{10, 11, 12, 13, 14, 15};

    $display("[TB] starting");
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_rf_rd", rf_rd, 0);
    checkOutput("rst_rf_wdata", rf_wdata, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_alu_ready", alu_ready, 1);
    checkOutput("rst_lsu_ready", lsu_ready, 1);

    // ALU-only write: accepted at edge 2, on the port between edges 3 and 4.
    alignStart();
    applyStimulus(1'b0, 5'd5, 64'hAA);
    observe(8);
    vec = '0;
    por = '0;
    for (int k = 0; k < 8; k++) begin
      vec[k] = h_we[k];
      por[k] = h_pend[k][5];
    end
    checkOutput("t1_we_history", vec, 32'b0000_1000);
    checkOutput("t1_pending5_history", por, 32'b0000_1100);
    checkOutput("t1_rd", h_rd[3], 5);
    checkOutput("t1_data", h_data[3], 64'hAA);
    checkOutput("t1_src", h_src[3], 0);

    // x0 discard.
    waitIdle();
    alignStart();
    applyStimulus(1'b1, 5'd0, 64'hFF);
    observe(8);
    vec = '0;
    por = '0;
    for (int k = 0; k < 8; k++) begin
      vec[k] = h_we[k];
      por    = por | h_pend[k];
    end
    checkOutput("t2_lsu_handshake", (h_lval[1] && h_lrdy[1]), 1);
    checkOutput("t2_we_history", vec, 0);
    checkOutput("t2_pending_or", por, 0);

    // Tie and round-robin.
    waitIdle();
    alignStart();
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 5'(i), 64'h100 + 64'(i));
    for (int i = 4; i <= 6; i++) applyStimulus(1'b1, 5'(i), 64'h100 + 64'(i));
    observe(12);
    vec = '0;
    for (int k = 0; k < 12; k++) vec[k] = h_we[k];
    checkOutput("t3_we_history", vec, 32'h1F8);
    for (int j = 0; j < 6; j++) begin
      checkOutput($sformatf("t3_rd_%0d", j), h_rd[3+j], 64'(exp_rr_rd[j]));
      checkOutput($sformatf("t3_src_%0d", j), h_src[3+j], 64'(exp_rr_src[j]));
      checkOutput($sformatf("t3_data_%0d", j), h_data[3+j], 64'h100 + 64'(exp_rr_rd[j]));
    end

    // Backpressure with both sources saturated.
    waitIdle();
    alignStart();
    for (int i = 10; i <= 15; i++) applyStimulus(1'b1, 5'(i), 64'h300 + 64'(i));
    for (int i = 20; i <= 23; i++) applyStimulus(1'b0, 5'(i), 64'h300 + 64'(i));
    observe(18);
    stall = 0;
    for (int k = 0; k < 18; k++) begin
      if (h_aval[k] && !h_ardy[k]) stall++;
      if (h_we[k]) begin
        if (h_src[k]) lwr.push_back(int'(h_rd[k]));
        else          awr.push_back(int'(h_rd[k]));
        checkOutput("t4_data", h_data[k], 64'h300 + 64'(h_rd[k]));
      end
    end
    checkOutput("t4_alu_backpressure", (stall > 0), 1);
    checkOutput("t4_alu_count", awr.size(), 4);
    checkOutput("t4_lsu_count", lwr.size(), 6);
    for (int j = 0; j < 4; j++)
      if (j < awr.size()) checkOutput($sformatf("t4_alu_order_%0d", j), awr[j], exp_a[j]);
    for (int j = 0; j < 6; j++)
      if (j < lwr.size()) checkOutput($sformatf("t4_lsu_order_%0d", j), lwr[j], exp_l[j]);

    // Reset mid-operation.
    waitIdle();
    alignStart();
    for (int i = 8; i <= 11; i++) applyStimulus(1'b0, 5'(i), 64'h400 + 64'(i));
    for (int i = 16; i <= 19; i++) applyStimulus(1'b1, 5'(i), 64'h400 + 64'(i));
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    alu_drv.delete();
    lsu_drv.delete();
    @(negedge clk);
    checkOutput("t5_pending_before_reset", (pending != '0), 1);
    checkOutput("t5_alu_ready_in_reset", alu_ready, 0);
    checkOutput("t5_lsu_ready_in_reset", lsu_ready, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_rf_we_after", rf_we, 0);
    checkOutput("t5_pending_after", pending, 0);
    checkOutput("t5_alu_ready_after", alu_ready, 1);
    checkOutput("t5_lsu_ready_after", lsu_ready, 1);
    observe(6);
    vec = '0;
    por = '0;
    for (int k = 0; k < 6; k++) begin
      vec[k] = h_we[k];
      por    = por | h_pend[k];
    end
    checkOutput("t5_no_write_after", vec, 0);
    checkOutput("t5_no_pending_after", por, 0);

    // Pending overlap on the same register.
    waitIdle();
    alignStart();
    applyStimulus(1'b0, 5'd7, 64'h71);
    applyStimulus(1'b0, 5'd7, 64'h72);
    observe(8);
    vec = '0;
    por = '0;
    for (int k = 0; k < 8; k++) begin
      vec[k] = h_pend[k][7];
      por[k] = h_we[k];
    end
    checkOutput("t6_pending7_history", vec, 32'b0001_1100);
    checkOutput("t6_we_history", por, 32'b0001_1000);
    checkOutput("t6_first_data", h_data[3], 64'h71);
    checkOutput("t6_second_data", h_data[4], 64'h72);

    waitIdle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 64-bit, 32-entry register file. It shares the file's single write port (RegWrite/RD/WriteData) between two write-back sources: the ALU and the load/store unit (LSU). Each source has a shallow per-source queue, and the arbiter grants between queues round-robin. It also publishes a pending-write bitmap, which decode uses to stall reads of registers with a write still in flight.

## Interface
Parameters:
- XLEN, 64, data width of a register.
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5.
- QDEPTH, 2, entries per source queue; must be a power of two ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request accepted this cycle when valid && ready.
- alu_rd  in  5  ALU destination register index.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU write-back request.
- lsu_ready  out  1  LSU request accepted this cycle when valid && ready.
- lsu_rd  in  5  LSU destination register index.
- lsu_data  in  XLEN  load data.
- rf_we  out  1  drives RegWrite of the register file.
- rf_rd  out  5  drives RD.
- rf_wdata  out  XLEN  drives WriteData.
- rf_src  out  1  source of the current write: 0 = ALU, 1 = LSU.
- pending  out  NREG  bit i is set while any queued or issuing write targets register i.

## Operation
- Handshake: a transfer occurs on a rising edge where valid && ready. src_ready = !queue_full && !reset; it is purely a function of registered state.
- A full queue accepts nothing, even in a cycle where it pops. There is no bypass path.
- Writes to rd = 0 are handshaken but discarded: no enqueue, no pending bit, no rf_we.
- Each queue is FIFO; order within one source is preserved.
- Both sources writing the same rd while both are in flight is forbidden upstream. Their relative order is not defined.
- Arbitration happens each cycle from the queue heads:
  - If only one queue is non-empty, grant it.
  - If both are non-empty, grant the source not granted last. last_grant updates only when both heads compete.
- Granted head pops; the output register loads rf_we=1, rf_rd, rf_wdata and rf_src.
- With no grant, rf_we=0 next cycle; rf_rd, rf_wdata and rf_src hold their values.
- pending is the OR of three terms: decoded rd of all valid ALU queue entries, decoded rd of all valid LSU queue entries, and rf_rd when rf_we=1. Bit 0 is always 0.
- Reset values:
  - queues empty, pointers 0.
  - rf_we=0, rf_rd=0, rf_wdata=0, rf_src=0.
  - pending=0, last_grant=LSU, so ALU wins the first tie.
  - alu_ready and lsu_ready are 0 during reset and 1 on the first cycle after it.
- Reset asserted mid-operation flushes all queued and issuing writes. rf_we=0 from the next edge, and no write to the register file completes.

## Timing
- Request accepted at edge N → entry visible at a queue head after N.
- Pop and output load at edge N+1 if granted, so rf_we=1 during cycle N+1..N+2.
- The register file commits the write while rf_we is high, which gives 2-cycle minimum accept-to-write latency.
- pending bit set the cycle after acceptance (after edge N). It clears the cycle after rf_we drops for that write, unless another entry targets the same rd.
- Sustained throughput is one register write per cycle total.
- With both sources saturated, each source gets a write every 2 cycles.
- Queue pointers wrap modulo QDEPTH. Full/empty use an extra pointer bit.
- Simultaneous enqueue and pop on a non-full queue is legal: occupancy stays unchanged.

## Structure
- Shared package regfile_pkg holds XLEN, NREG, the RIDX_W=5 constant, the typedef wb_req_t {rd, data}, and the enum wb_src_e {SRC_ALU, SRC_LSU}.
- One sub-module, wb_fifo: a parameterized sync FIFO of wb_req_t with push/pop/full/empty and a valid-entry rd-bitmap output.
- The arbiter instantiates wb_fifo twice.

## Test plan
- ALU-only write: after reset, send alu rd=5, data=0xAA.
  - rf_we=1 with rf_rd=5, rf_wdata=0xAA, rf_src=0 exactly 2 cycles after acceptance.
  - pending[5] high from cycle +1 until rf_we drops.
- x0 discard: lsu rd=0, data=0xFF → lsu_ready=1, no rf_we, pending stays 0.
- Tie and round-robin: ALU (rd 1, 2, 3) and LSU (rd 4, 5, 6) presented together with valid held.
  - Write order is 1, 4, 2, 5, 3, 6.
  - rf_we stays high for 6 consecutive cycles.
- Backpressure: hold ALU valid with the writes stalled behind a saturated LSU.
  - alu_ready drops once its 2 entries are queued.
  - There is no acceptance on the cycle a full queue pops.
  - All accepted data appears in order with nothing lost or duplicated.
- Reset mid-operation: fill both queues, then assert reset for 1 cycle.
  - rf_we=0 and pending=0 the next cycle.
  - Ready signals are 0 during reset.
  - No queued data is written afterward.
- Pending overlap: two ALU writes to rd=7 back-to-back.
  - pending[7] stays continuously high until the second write's rf_we cycle ends.
